// File: rtl/mcs_pkg.sv
// Shared constants and helpers for the multi-channel data synchronizer.
// Edge-detection mode selectors and the channel-index width derivation.
package mcs_pkg;

    localparam int EDGE_RISING = 0;
    localparam int EDGE_TOGGLE = 1;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_synchronizer.sv
// Multi-flop synchroniser for a bus of independent level signals.
// Each bit is resynchronised separately; no bus coherency is implied.
module bus_synchronizer #(
    parameter int BUS_WIDTH   = 8,
    parameter int STAGE_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] async_data,
    output logic [BUS_WIDTH-1:0] sync_data
);

    logic [BUS_WIDTH-1:0] stages [STAGE_COUNT];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGE_COUNT; s++) begin
                stages[s] <= '0;
            end
        end else begin
            stages[0] <= async_data;
            for (int s = 1; s < STAGE_COUNT; s++) begin
                stages[s] <= stages[s-1];
            end
        end
    end

    assign sync_data = stages[STAGE_COUNT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant,
// wrapping modulo N.
module rr_arbiter
    import mcs_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CH_W = ch_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] last_grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_req
);

    logic found;
    int   idx;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                grant_idx = CH_W'(idx);
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/multi_channel_data_synchronizer.sv
// Destination-domain receiver: synchronises per-channel valid strobes, captures
// each channel's bus on an event and serialises the words onto one valid/ready stream.
module multi_channel_data_synchronizer
    import mcs_pkg::*;
#(
    parameter  int STAGE_COUNT = 2,
    parameter  int BUS_WIDTH   = 8,
    parameter  int CHANNELS    = 4,
    parameter  int TOGGLE_MODE = EDGE_RISING,
    localparam int CH_W        = ch_width(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           async_valid,
    input  logic [CHANNELS*BUS_WIDTH-1:0] async_data,
    input  logic                          out_ready,
    input  logic                          overflow_clear,
    output logic                          out_valid,
    output logic [BUS_WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]               out_channel,
    output logic [CHANNELS-1:0]           pending,
    output logic [CHANNELS-1:0]           overflow
);

    logic [CHANNELS-1:0]  sync;
    logic [CHANNELS-1:0]  prev;
    logic [CHANNELS-1:0]  evt;
    logic [CHANNELS-1:0]  capture;
    logic [CHANNELS-1:0]  pending_next;
    logic [CHANNELS-1:0]  overflow_next;
    logic [BUS_WIDTH-1:0] hold [CHANNELS];
    logic [CH_W-1:0]      last_grant;
    logic [CH_W-1:0]      grant_idx;
    logic                 any_req;
    logic                 load;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
        bus_synchronizer #(
            .BUS_WIDTH  (1),
            .STAGE_COUNT(STAGE_COUNT)
        ) u_sync (
            .clk       (clk),
            .reset     (reset),
            .async_data(async_valid[i]),
            .sync_data (sync[i])
        );
    end

    assign evt = (TOGGLE_MODE == EDGE_TOGGLE) ? (sync ^ prev) : (sync & ~prev);

    rr_arbiter #(
        .N(CHANNELS)
    ) u_arb (
        .req       (pending),
        .last_grant(last_grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // The output register is free when empty or when its word leaves this cycle.
    assign load = (!out_valid || out_ready) && any_req;

    always_comb begin
        pending_next  = pending;
        overflow_next = overflow_clear ? '0 : overflow;
        capture       = '0;
        if (load) begin
            pending_next[grant_idx] = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (evt[i]) begin
                if (!pending[i] || (load && grant_idx == CH_W'(i))) begin
                    capture[i]      = 1'b1;
                    pending_next[i] = 1'b1;
                end else begin
                    overflow_next[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev        <= '0;
            pending     <= '0;
            overflow    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            last_grant  <= CH_W'(CHANNELS - 1);
        end else begin
            prev     <= sync;
            pending  <= pending_next;
            overflow <= overflow_next;
            if (load) begin
                out_valid   <= 1'b1;
                out_data    <= hold[grant_idx];
                out_channel <= grant_idx;
                last_grant  <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the holding registers are reset too, so a reset discards every held word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (capture[i]) begin
                    hold[i] <= async_data[i*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
    end

endmodule
